// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver state encoding and the
// default frame geometry used by both the transmit and receive ends.
package serial_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DEFAULT_WIDTH        = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Mod-CLKS_PER_BIT bit-period counter with synchronous clear; flags the
// mid-bit point (half) and the end of each bit period (full).
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half,
    output logic full
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_rx.sv
// Framed serial receiver: start-bit qualification, mid-bit sampling of
// LSB-first data, optional even parity and stop-bit check.
module serial_rx
    import serial_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             PAR_ERR,
    output logic             FRAME_ERR,
    output logic             BUSY
);

    rx_state_t        state;
    logic [4:0]       bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;
    logic             half;
    logic             full;
    logic             timer_clear;

    // Timer is held at zero while idle so t0 starts a fresh count; it is
    // re-zeroed at the start-bit midpoint so later samples land mid-bit.
    assign timer_clear = (state == IDLE) || ((state == START) && half);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) timer (
        .clk  (CLK),
        .rst  (RST),
        .clear(timer_clear),
        .half (half),
        .full (full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            DOUT      <= '0;
            VALID     <= 1'b0;
            PAR_ERR   <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (!SIN) begin
                        state <= START;
                        BUSY  <= 1'b1;
                    end
                end
                START: begin
                    if (half) begin
                        if (SIN) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (full) begin
                        shreg <= (shreg >> 1) | (WIDTH'(SIN) << (WIDTH - 1));
                        if (bit_cnt == 5'(WIDTH - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                PAR: begin
                    if (full) begin
                        par_bit <= SIN;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (full) begin
                        DOUT      <= shreg;
                        PAR_ERR   <= (PARITY != 0) && ((^shreg) ^ par_bit);
                        FRAME_ERR <= !SIN;
                        VALID     <= 1'b1;
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: frames are generated from the wire format,
// expected words and strobe cycles queued, and a monitor checks each VALID.
module tb_serial_rx;

    localparam int W = 8;
    localparam int C = 4;
    localparam int P = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic [W-1:0] dout;
    logic         valid;
    logic         par_err;
    logic         frame_err;
    logic         busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         pe;
        logic         fe;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    serial_rx #(
        .WIDTH       (W),
        .CLKS_PER_BIT(C),
        .PARITY      (P)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .SIN      (sin),
        .DOUT     (dout),
        .VALID    (valid),
        .PAR_ERR  (par_err),
        .FRAME_ERR(frame_err),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every VALID must match the oldest queued frame, at the cycle
    // implied by the frame's start edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("dout", 32'(dout), 32'(mon_e.d));
                check("par_err", 32'(par_err), 32'(mon_e.pe));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("valid_cycle", cyc, mon_e.at);
            end
        end
    end

    // Entered and left at 1ns after a rising edge.
    task automatic send_frame(input logic [W-1:0] d, input bit flip, input bit stop);
        logic [W+2:0] bits;
        exp_t e;
        e.d  = d;
        e.pe = flip;
        e.fe = !stop;
        e.at = cyc + 1 + C / 2 + (W + 1 + P) * C;
        sb.push_back(e);
        bits = {stop, (^d) ^ flip, d, 1'b0};
        for (int i = 0; i < W + 3; i++) begin
            sin = bits[i];
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        sin = 1'b1;
        repeat (n * C) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        bit           flip;
        bit           stop;
        int           nb;
        int           k;

        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        repeat (100) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_dout", 32'(dout), 32'd0);
        end
        @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0);
        idle_bits(2);

        // One-cycle low pulse must be rejected at the start-bit midpoint.
        sin = 1'b0;
        @(posedge clk);
        #1;
        sin = 1'b1;
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("glitch_busy_cycles", nb, 2);
        check("glitch_dout", 32'(dout), 32'h81);
        @(posedge clk);
        #1;

        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle_bits(1);

        // Abort a frame with reset during data bit 3.
        d = 8'hC6;
        sin = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sin = d[i];
            repeat (C) @(posedge clk);
            #1;
        end
        sin = d[3];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_flags", {30'd0, par_err, frame_err}, 32'd0);
        idle_bits(3);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle_bits(2);

        for (int n = 0; n < 20; n++) begin
            d    = W'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, flip, stop);
            // A low stop bit followed at once by a start bit would retrigger early.
            idle_bits(stop ? $urandom_range(0, 2) : $urandom_range(1, 2));
        end
        idle_bits(2);

        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
